alu_op_sequencer: RTL and testbench

- Sequences a shared 32-bit execution unit (add/mul/div) across a multi-operand UART payload.
- Sits between the UART packet front end and the arithmetic units.
  - After the header is parsed, it takes a start pulse, opcode and byte length.
  - It pulls payload bytes from the RX stream and assembles 32-bit little-endian operands.
  - It issues pairwise reductions (acc OP word) to the execution unit and returns the final 32-bit result with a done pulse.

---
 rtl/alu_op_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Folds a UART payload of 32-bit little-endian words through a shared add/mul/div unit.
// Define ALU_SEQ_TIMEOUT_EN to add a watchdog on the unit handshake and result.

module alu_op_sequencer #(
    parameter int datawidth_p = 8,
    parameter int wordwidth_p = 32,
    parameter int timeout_p   = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [7:0]             opcode_i,
    input  logic [15:0]            len_i,
    input  logic [datawidth_p-1:0] rx_data_i,
    input  logic                   rx_valid_i,
    output logic                   rx_ready_o,
    output logic [wordwidth_p-1:0] op_a_o,
    output logic [wordwidth_p-1:0] op_b_o,
    output logic [1:0]             op_sel_o,
    output logic                   op_valid_o,
    input  logic                   op_ready_i,
    input  logic [wordwidth_p-1:0] op_result_i,
    input  logic                   op_result_valid_i,
    output logic [wordwidth_p-1:0] result_o,
    output logic                   done_o,
    output logic                   error_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_ISSUE,
        ST_WAIT_RES,
        ST_DRAIN,
        ST_DONE
    } state_e;

    if (wordwidth_p != 4 * datawidth_p || timeout_p < 2) begin : g_param_check
        $error("alu_op_sequencer: wordwidth_p must be 4*datawidth_p and timeout_p >= 2");
    end

    state_e                   state_q, state_d;
    logic [1:0]               sel_q, sel_d;
    logic [15:0]              remaining_q, remaining_d;
    logic [1:0]               byte_idx_q, byte_idx_d;
    logic [wordwidth_p-1:0]   word_q, word_d;
    logic [wordwidth_p-1:0]   acc_q, acc_d;
    logic                     first_q, first_d;
    logic                     err_q, err_d;
    logic                     rx_ready_q, rx_ready_d;
    logic                     op_valid_q, op_valid_d;
    logic [wordwidth_p-1:0]   op_a_q, op_a_d;
    logic [wordwidth_p-1:0]   op_b_q, op_b_d;
    logic [1:0]               op_sel_q, op_sel_d;
    logic [wordwidth_p-1:0]   result_q, result_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;
    logic                     op_supported;

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int TimerW = $clog2(timeout_p);
    logic [TimerW-1:0]        timer_q, timer_d;
`endif

    assign op_supported = (opcode_i == 8'h10) || (opcode_i == 8'h11) || (opcode_i == 8'h12);

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        remaining_d = remaining_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        acc_d       = acc_q;
        first_d     = first_q;
        err_d       = err_q;
        rx_ready_d  = rx_ready_q;
        op_valid_d  = op_valid_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_sel_d    = op_sel_q;
        result_d    = result_q;
        done_d      = 1'b0;
        error_d     = error_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    acc_d       = '0;
                    word_d      = '0;
                    byte_idx_d  = '0;
                    first_d     = 1'b1;
                    err_d       = 1'b0;
                    error_d     = 1'b0;
                    remaining_d = len_i;
                    // Supported opcodes 0x10..0x12 map directly onto unit select 0..2.
                    sel_d       = opcode_i[1:0];
                    if (len_i == 16'd0) begin
                        state_d = ST_DONE;
                    end else if (len_i[1:0] != 2'b00 || !op_supported) begin
                        err_d      = 1'b1;
                        rx_ready_d = 1'b1;
                        state_d    = ST_DRAIN;
                    end else begin
                        rx_ready_d = 1'b1;
                        state_d    = ST_COLLECT;
                    end
                end
            end
            ST_COLLECT: begin
                if (rx_valid_i && rx_ready_q) begin
                    for (int i = 0; i < 4; i++) begin
                        if (byte_idx_q == 2'(i)) word_d[i*datawidth_p +: datawidth_p] = rx_data_i;
                    end
                    remaining_d = remaining_q - 16'd1;
                    byte_idx_d  = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        first_d = 1'b0;
                        if (first_q) begin
                            acc_d = word_d;
                            if (remaining_d == 16'd0) begin
                                rx_ready_d = 1'b0;
                                state_d    = ST_DONE;
                            end
                        end else begin
                            op_a_d     = acc_q;
                            op_b_d     = word_d;
                            op_sel_d   = sel_q;
                            op_valid_d = 1'b1;
                            rx_ready_d = 1'b0;
                            state_d    = ST_ISSUE;
                        end
                    end
                end
            end
            ST_ISSUE: begin
                // A result strobe coinciding with the handshake is deliberately ignored here.
                if (op_valid_q && op_ready_i) begin
                    op_valid_d = 1'b0;
                    state_d    = ST_WAIT_RES;
                end
            end
            ST_WAIT_RES: begin
                if (op_result_valid_i) begin
                    acc_d = op_result_i;
                    if (remaining_q != 16'd0) begin
                        rx_ready_d = 1'b1;
                        state_d    = ST_COLLECT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DRAIN: begin
                if (rx_valid_i && rx_ready_q) begin
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_d == 16'd0) begin
                        rx_ready_d = 1'b0;
                        state_d    = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef ALU_SEQ_TIMEOUT_EN
        timer_d = '0;
        if ((state_q == ST_ISSUE || state_q == ST_WAIT_RES) && state_d == state_q) begin
            if (timer_q == TimerW'(timeout_p - 1)) begin
                err_d      = 1'b1;
                op_valid_d = 1'b0;
                rx_ready_d = 1'b0;
                state_d    = ST_DONE;
            end else begin
                timer_d = timer_q + TimerW'(1);
            end
        end
`endif

        // Every path into Done publishes the run outcome in the same cycle.
        if (state_d == ST_DONE && state_q != ST_DONE) begin
            done_d   = 1'b1;
            error_d  = err_d;
            result_d = err_d ? '0 : acc_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            remaining_q <= '0;
            byte_idx_q  <= '0;
            word_q      <= '0;
            acc_q       <= '0;
            first_q     <= 1'b0;
            err_q       <= 1'b0;
            rx_ready_q  <= 1'b0;
            op_valid_q  <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_sel_q    <= '0;
            result_q    <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
            timer_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            remaining_q <= remaining_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            acc_q       <= acc_d;
            first_q     <= first_d;
            err_q       <= err_d;
            rx_ready_q  <= rx_ready_d;
            op_valid_q  <= op_valid_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_sel_q    <= op_sel_d;
            result_q    <= result_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef ALU_SEQ_TIMEOUT_EN
            timer_q     <= timer_d;
`endif
        end
    end

    assign rx_ready_o = rx_ready_q;
    assign op_valid_o = op_valid_q;
    assign op_a_o     = op_a_q;
    assign op_b_o     = op_b_q;
    assign op_sel_o   = op_sel_q;
    assign result_o   = result_q;
    assign done_o     = done_q;
    assign error_o    = error_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed and random payloads against a word-level reference fold,
// with an emulated execution unit that adds backpressure, result latency and stray strobes.

module tb_alu_op_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [7:0]  opcode_i = 8'h00;
    logic [15:0] len_i = 16'h0000;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_valid_i = 1'b0;
    logic        rx_ready_o;
    logic [31:0] op_a_o, op_b_o;
    logic [1:0]  op_sel_o;
    logic        op_valid_o;
    logic        op_ready_i = 1'b0;
    logic [31:0] op_result_i = 32'h0;
    logic        op_result_valid_i = 1'b0;
    logic [31:0] result_o;
    logic        done_o, error_o;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0]  rx_q[$];
    int          accepted = 0;
    int          gap = 0;
    bit          pend_xfer = 0;

    bit          unit_pending = 0, unit_in_req = 0, no_result = 0;
    int          force_wait = -1, wait_left = 0, res_delay = 0;
    int          req_count = 0, valid_cycles = 0;
    logic [31:0] pend_val = 32'h0;
    bit          prev_valid = 0, prev_ready = 0;
    logic [31:0] prev_a = 32'h0, prev_b = 32'h0;
    logic [1:0]  prev_sel = 2'b00;

    alu_op_sequencer #(.datawidth_p(8), .wordwidth_p(32), .timeout_p(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .opcode_i(opcode_i), .len_i(len_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .op_a_o(op_a_o), .op_b_o(op_b_o), .op_sel_o(op_sel_o), .op_valid_o(op_valid_o),
        .op_ready_i(op_ready_i), .op_result_i(op_result_i), .op_result_valid_i(op_result_valid_i),
        .result_o(result_o), .done_o(done_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] unitFn(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel);
        case (sel)
            2'd0:    return a + b;
            2'd1:    return a * b;
            2'd2:    return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            default: return 32'h0;
        endcase
    endfunction

    // Word-level view of a run: fold the payload words left-to-right with the requested operator.
    function automatic void refModel(input logic [7:0] opc, input int len, input logic [7:0] bytes[$],
                                     output logic [31:0] res, output logic err, output int nacc, output int nreq);
        int          nwords;
        logic [31:0] w;
        logic [1:0]  sel;
        res = 32'h0; err = 1'b0; nacc = 0; nreq = 0;
        if (len == 0) return;
        nacc = len;
        if ((len % 4) != 0 || !(opc inside {8'h10, 8'h11, 8'h12})) begin
            err = 1'b1;
            return;
        end
        sel    = 2'(opc - 8'h10);
        nwords = len / 4;
        nreq   = nwords - 1;
        for (int i = 0; i < nwords; i++) begin
            w   = {bytes[4*i+3], bytes[4*i+2], bytes[4*i+1], bytes[4*i]};
            res = (i == 0) ? w : unitFn(res, w, sel);
        end
    endfunction

    // RX source: holds each byte until accepted, then inserts a random bubble.
    always @(negedge clk_i) begin
        if (pend_xfer && rx_q.size() > 0) begin
            void'(rx_q.pop_front());
            accepted++;
            gap = $urandom_range(0, 3);
        end
        if (gap > 0) begin
            rx_valid_i = 1'b0;
            gap--;
        end else if (rx_q.size() > 0) begin
            rx_valid_i = 1'b1;
            rx_data_i  = rx_q[0];
        end else begin
            rx_valid_i = 1'b0;
        end
        pend_xfer = rx_valid_i && rx_ready_o;
    end

    // Execution unit emulation plus request-protocol checks.
    always @(negedge clk_i) begin
        op_ready_i        = 1'b0;
        op_result_valid_i = 1'b0;
        if (rst_i) begin
            unit_pending = 0;
            unit_in_req  = 0;
        end else begin
            if (op_valid_o) valid_cycles++;
            if (prev_valid && !prev_ready) begin
                checkOutput("op_hold_valid", op_valid_o, 1);
                if (op_valid_o) begin
                    checkOutput("op_a_stable", op_a_o, prev_a);
                    checkOutput("op_b_stable", op_b_o, prev_b);
                    checkOutput("op_sel_stable", op_sel_o, prev_sel);
                end
            end
            if (prev_valid && prev_ready) checkOutput("op_valid_drop", op_valid_o, 0);
            if (op_valid_o || unit_pending) checkOutput("rdy_busy", rx_ready_o, 0);
            if (unit_pending) begin
                if (!no_result) begin
                    if (res_delay == 0) begin
                        op_result_valid_i = 1'b1;
                        op_result_i       = pend_val;
                        unit_pending      = 0;
                    end else begin
                        res_delay--;
                    end
                end
            end else if (op_valid_o) begin
                if (!unit_in_req) begin
                    unit_in_req = 1;
                    wait_left   = (force_wait >= 0) ? force_wait : $urandom_range(0, 4);
                end
                if (wait_left == 0) begin
                    op_ready_i   = 1'b1;
                    pend_val     = unitFn(op_a_o, op_b_o, op_sel_o);
                    unit_pending = 1;
                    unit_in_req  = 0;
                    res_delay    = $urandom_range(0, 3);
                    req_count++;
                    if ($urandom_range(0, 3) == 0) begin
                        op_result_valid_i = 1'b1;
                        op_result_i       = 32'hBAD0_BAD0;
                    end
                end else begin
                    wait_left--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                op_result_valid_i = 1'b1;
                op_result_i       = $urandom;
            end
        end
        prev_valid = op_valid_o;
        prev_ready = op_ready_i;
        prev_a     = op_a_o;
        prev_b     = op_b_o;
        prev_sel   = op_sel_o;
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rx_ready"}, rx_ready_o, 0);
        checkOutput({tag, "_op_valid"}, op_valid_o, 0);
        checkOutput({tag, "_done"}, done_o, 0);
        checkOutput({tag, "_error"}, error_o, 0);
        checkOutput({tag, "_result"}, result_o, 0);
        checkOutput({tag, "_op_a"}, op_a_o, 0);
        checkOutput({tag, "_op_b"}, op_b_o, 0);
        checkOutput({tag, "_op_sel"}, op_sel_o, 0);
    endtask

    // Loads the payload (plus trailing junk that must never be taken) and raises start for one cycle.
    task automatic startRun(input logic [7:0] opc, input int len, input logic [7:0] bytes[$]);
        @(negedge clk_i);
        #1;
        rx_q.delete();
        foreach (bytes[i]) rx_q.push_back(bytes[i]);
        repeat (4) rx_q.push_back(8'($urandom));
        accepted     = 0;
        req_count    = 0;
        valid_cycles = 0;
        @(negedge clk_i);
        start_i  = 1'b1;
        opcode_i = opc;
        len_i    = 16'(len);
    endtask

    task automatic applyStimulus(input logic [7:0] opc, input int len, input logic [7:0] bytes[$], input string tag);
        logic [31:0] exp_res;
        logic        exp_err;
        int          exp_acc, exp_req, cycles;
        bit          done_seen;
        refModel(opc, len, bytes, exp_res, exp_err, exp_acc, exp_req);
        startRun(opc, len, bytes);
        cycles    = 0;
        done_seen = 0;
        while (!done_seen && cycles < 2000) begin
            @(negedge clk_i);
            start_i = 1'b0;
            cycles++;
            if (cycles == 1) checkOutput({tag, "_err_clear"}, error_o, 0);
            if (done_o) begin
                done_seen = 1;
            end else if (cycles == 3) begin
                start_i  = 1'b1;
                opcode_i = 8'h11;
                len_i    = 16'h0000;
            end
        end
        checkOutput({tag, "_done_seen"}, 32'(done_seen), 1);
        if (done_seen) begin
            checkOutput({tag, "_result"}, result_o, exp_res);
            checkOutput({tag, "_error"}, error_o, 32'(exp_err));
            if (len == 0) checkOutput({tag, "_latency"}, cycles, 1);
            @(negedge clk_i);
            checkOutput({tag, "_done_pulse"}, done_o, 0);
            checkOutput({tag, "_result_hold"}, result_o, exp_res);
            checkOutput({tag, "_accepted"}, accepted, exp_acc);
            checkOutput({tag, "_requests"}, req_count, exp_req);
            checkOutput({tag, "_valid_seen"}, 32'(valid_cycles > 0), 32'(exp_req > 0));
        end
    endtask

    initial begin
        logic [7:0] bytes[$];
        int         waited, done_cnt, len_r, pick;
        logic [7:0] opc_r;

        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        checkAllZero("reset");
        rst_i = 1'b0;

        bytes = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
        applyStimulus(8'h10, 12, bytes, "add");

        force_wait = 5;
        bytes = '{8'h07, 8'h00, 8'h00, 8'h00, 8'h06, 8'h00, 8'h00, 8'h00};
        applyStimulus(8'h11, 8, bytes, "mul_bp");
        force_wait = -1;

        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        applyStimulus(8'h10, 6, bytes, "err_len6");
        bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        applyStimulus(8'h33, 8, bytes, "err_opc");

        bytes.delete();
        applyStimulus(8'h10, 0, bytes, "len0");

        bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        applyStimulus(8'h12, 4, bytes, "len4");

        bytes = '{8'h64, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
        applyStimulus(8'h12, 8, bytes, "div");

        // Reset while the sequencer waits for a result that never comes.
        no_result = 1;
        bytes.delete();
        for (int i = 0; i < 12; i++) bytes.push_back(8'($urandom));
        startRun(8'h11, 12, bytes);
        waited = 0;
        while (!unit_pending && waited < 200) begin
            @(negedge clk_i);
            start_i = 1'b0;
            waited++;
        end
        checkOutput("rst_reach_wait", 32'(unit_pending), 1);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        checkAllZero("rst_mid");
        #1;
        rst_i     = 1'b0;
        no_result = 0;
        done_cnt  = 0;
        repeat (8) begin
            @(negedge clk_i);
            if (done_o) done_cnt++;
        end
        checkOutput("rst_no_done", done_cnt, 0);

        for (int r = 0; r < 12; r++) begin
            pick  = $urandom_range(0, 9);
            opc_r = (pick == 9) ? 8'h20 : 8'h10 + 8'($urandom_range(0, 2));
            len_r = (pick == 8) ? $urandom_range(1, 15) : 4 * $urandom_range(1, 5);
            bytes.delete();
            for (int i = 0; i < len_r; i++) bytes.push_back(8'($urandom));
            applyStimulus(opc_r, len_r, bytes, "rand");
        end

`ifdef ALU_SEQ_TIMEOUT_EN
        no_result = 1;
        bytes.delete();
        for (int i = 0; i < 12; i++) bytes.push_back(8'($urandom));
        startRun(8'h10, 12, bytes);
        waited = 0;
        while (!done_o && waited < 200) begin
            @(negedge clk_i);
            start_i = 1'b0;
            waited++;
        end
        checkOutput("tmo_done_seen", done_o, 1);
        checkOutput("tmo_error", error_o, 1);
        checkOutput("tmo_result", result_o, 0);
        @(negedge clk_i);
        checkOutput("tmo_accepted", accepted, 8);
        checkOutput("tmo_requests", req_count, 1);
        #1;
        unit_pending = 0;
        no_result    = 0;
`endif

        repeat (3) @(negedge clk_i);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
